// File: rtl/data_mem_mmio.sv
// Data-side memory slave: word RAM plus a small MMIO window
// holding the LED register, cycle counter, compare register and match flag.
module data_mem_mmio #(
  parameter int          DEPTH     = 256,
  parameter logic [31:0] MMIO_BASE = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite_M,
  input  logic [31:0] aluresult_M,
  input  logic [31:0] writedata_M,
  output logic [31:0] readdata_M,
  output logic [7:0]  leds,
  output logic        timer_flag
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0] r_mem [DEPTH];
  logic [7:0]  r_led;
  logic [31:0] r_cycle;
  logic [31:0] r_cmp;
  logic        r_flag;

  logic          w_is_ram;
  logic          w_is_mmio;
  logic [AW-1:0] w_idx;
  logic [1:0]    w_off;
  logic          w_wr_ram;
  logic          w_wr_led;
  logic          w_wr_cyc;
  logic          w_wr_cmp;
  logic          w_wr_sts;
  logic          w_match;

  assign w_is_ram  = (aluresult_M[31:AW+2] == '0);
  assign w_is_mmio = ((aluresult_M & 32'hFFFF_FFF0) == MMIO_BASE);
  assign w_idx     = aluresult_M[AW+1:2];
  assign w_off     = aluresult_M[3:2];

  assign w_wr_ram = memwrite_M && w_is_ram;
  assign w_wr_led = memwrite_M && w_is_mmio && (w_off == 2'd0);
  assign w_wr_cyc = memwrite_M && w_is_mmio && (w_off == 2'd1);
  assign w_wr_cmp = memwrite_M && w_is_mmio && (w_off == 2'd2);
  assign w_wr_sts = memwrite_M && w_is_mmio && (w_off == 2'd3);

  // a zero compare value disables matching entirely
  assign w_match = (r_cmp != 32'd0) && (r_cycle == r_cmp);

  always_ff @(posedge clk) begin
    if (w_wr_ram)
      r_mem[w_idx] <= writedata_M;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_led   <= 8'd0;
      r_cycle <= 32'd0;
      r_cmp   <= 32'd0;
      r_flag  <= 1'b0;
    end else begin
      r_cycle <= w_wr_cyc ? 32'd0 : r_cycle + 32'd1;
      if (w_wr_led)
        r_led <= writedata_M[7:0];
      if (w_wr_cmp)
        r_cmp <= writedata_M;
      // set beats a same-cycle write-1-clear
      if (w_match)
        r_flag <= 1'b1;
      else if (w_wr_sts && writedata_M[0])
        r_flag <= 1'b0;
    end
  end

  always_comb begin
    readdata_M = 32'd0;
    if (w_is_ram) begin
      readdata_M = r_mem[w_idx];
    end else if (w_is_mmio) begin
      unique case (w_off)
        2'd0: readdata_M = {24'd0, r_led};
        2'd1: readdata_M = r_cycle;
        2'd2: readdata_M = r_cmp;
        2'd3: readdata_M = {31'd0, r_flag};
      endcase
    end
  end

  assign leds       = r_led;
  assign timer_flag = r_flag;

endmodule

// File: tb/tb_data_mem_mmio.sv
// Directed bench for data_mem_mmio: RAM, LED, counter,
// compare/flag behaviour and unmapped accesses.
module tb_data_mem_mmio;

  logic        clk = 1'b0;
  logic        reset;
  logic        memwrite_M;
  logic [31:0] aluresult_M;
  logic [31:0] writedata_M;
  logic [31:0] readdata_M;
  logic [7:0]  leds;
  logic        timer_flag;

  int checks   = 0;
  int failures = 0;

  data_mem_mmio dut (
    .clk         (clk),
    .reset       (reset),
    .memwrite_M  (memwrite_M),
    .aluresult_M (aluresult_M),
    .writedata_M (writedata_M),
    .readdata_M  (readdata_M),
    .leds        (leds),
    .timer_flag  (timer_flag)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drive(input logic we, input logic [31:0] a,
                       input logic [31:0] d);
    memwrite_M  = we;
    aluresult_M = a;
    writedata_M = d;
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 32'd0, 32'd0);
    ticks(2);
    chk("rst_leds", {24'd0, leds}, 32'd0);
    chk("rst_flag", {31'd0, timer_flag}, 32'd0);
    drive(1'b0, 32'h8000_0008, 32'd0);
    chk("rst_cmp", readdata_M, 32'd0);
    reset = 1'b0;

    // counter starts at 0 in the first cycle after reset
    drive(1'b0, 32'h8000_0004, 32'd0);
    chk("cyc_k0", readdata_M, 32'd0);
    ticks(4);
    chk("cyc_k4", readdata_M, 32'd4);

    // RAM store/load with read-old
    drive(1'b1, 32'h0000_0000, 32'hCAFE_F00D);
    tick();
    drive(1'b1, 32'h0000_0010, 32'h1111_1111);
    tick();
    drive(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    chk("ram_read_old", readdata_M, 32'h1111_1111);
    tick();
    drive(1'b0, 32'h0000_0010, 32'd0);
    chk("ram_rd_10", readdata_M, 32'hDEAD_BEEF);
    drive(1'b0, 32'h0000_0013, 32'd0);
    chk("ram_rd_13", readdata_M, 32'hDEAD_BEEF);
    drive(1'b0, 32'h0000_0000, 32'd0);
    chk("ram_rd_0", readdata_M, 32'hCAFE_F00D);

    // LED register and reset discarding an MMIO store
    drive(1'b1, 32'h8000_0000, 32'h1234_56A5);
    tick();
    chk("led_pins", {24'd0, leds}, 32'h0000_00A5);
    drive(1'b0, 32'h8000_0000, 32'd0);
    chk("led_rd", readdata_M, 32'h0000_00A5);
    reset = 1'b1;
    drive(1'b1, 32'h8000_0000, 32'h0000_00FF);
    tick();
    reset = 1'b0;
    drive(1'b0, 32'h8000_0004, 32'd0);
    chk("led_reset", {24'd0, leds}, 32'd0);
    chk("cyc_after_rst", readdata_M, 32'd0);

    // counter clear by write
    ticks(3);
    chk("cyc_3", readdata_M, 32'd3);
    drive(1'b1, 32'h8000_0004, 32'h0000_ABCD);
    tick();
    drive(1'b0, 32'h8000_0004, 32'd0);
    chk("cyc_clr0", readdata_M, 32'd0);
    tick();
    chk("cyc_clr1", readdata_M, 32'd1);

    // timer match at CMP=20
    drive(1'b1, 32'h8000_0008, 32'd20);
    tick();
    drive(1'b1, 32'h8000_0004, 32'd0);
    tick();
    drive(1'b0, 32'h8000_0008, 32'd0);
    chk("cmp_rd", readdata_M, 32'd20);
    ticks(20);
    drive(1'b0, 32'h8000_0004, 32'd0);
    chk("cyc_20", readdata_M, 32'd20);
    chk("flag_pre", {31'd0, timer_flag}, 32'd0);
    tick();
    chk("flag_set", {31'd0, timer_flag}, 32'd1);
    drive(1'b1, 32'h8000_000C, 32'd1);
    chk("sts_rd1", readdata_M, 32'd1);
    tick();
    drive(1'b0, 32'h8000_000C, 32'd0);
    chk("flag_clr", {31'd0, timer_flag}, 32'd0);
    chk("sts_rd0", readdata_M, 32'd0);

    // CMP=0 disables matching even as CYCLE passes 0
    drive(1'b1, 32'h8000_0008, 32'd0);
    tick();
    drive(1'b1, 32'h8000_0004, 32'd0);
    tick();
    drive(1'b0, 32'h8000_0004, 32'd0);
    ticks(3);
    chk("cmp0_noset", {31'd0, timer_flag}, 32'd0);

    // set/clear collision: set wins
    drive(1'b1, 32'h8000_0008, 32'd5);
    tick();
    drive(1'b1, 32'h8000_0004, 32'd0);
    tick();
    drive(1'b0, 32'h8000_0004, 32'd0);
    ticks(5);
    chk("cyc_5", readdata_M, 32'd5);
    drive(1'b1, 32'h8000_000C, 32'd1);
    tick();
    chk("collide_set", {31'd0, timer_flag}, 32'd1);
    drive(1'b1, 32'h8000_000C, 32'd0);
    tick();
    chk("wr0_noeffect", {31'd0, timer_flag}, 32'd1);
    drive(1'b1, 32'h8000_000C, 32'd1);
    tick();
    chk("flag_clr2", {31'd0, timer_flag}, 32'd0);

    // CMP rewrite during pending match uses old CMP
    drive(1'b1, 32'h8000_0004, 32'd0);
    tick();
    drive(1'b0, 32'h8000_0004, 32'd0);
    ticks(5);
    drive(1'b1, 32'h8000_0008, 32'd100);
    tick();
    chk("cmp_pending", {31'd0, timer_flag}, 32'd1);
    drive(1'b1, 32'h8000_000C, 32'd1);
    tick();

    // unmapped accesses
    drive(1'b1, 32'h4000_0000, 32'hFFFF_FFFF);
    tick();
    drive(1'b0, 32'h4000_0000, 32'd0);
    chk("unmap_rd", readdata_M, 32'd0);
    drive(1'b0, 32'h8000_0010, 32'd0);
    chk("unmap_rd2", readdata_M, 32'd0);
    drive(1'b0, 32'h0000_0000, 32'd0);
    chk("unmap_ram0", readdata_M, 32'hCAFE_F00D);
    drive(1'b0, 32'h8000_0008, 32'd0);
    chk("unmap_cmp", readdata_M, 32'd100);
    chk("unmap_leds", {24'd0, leds}, 32'd0);
    chk("unmap_flag", {31'd0, timer_flag}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_mem_mmio.md
Name: data_mem_mmio

Overview:
- Memory-stage slave of the pipelined core: consumes memwrite_M, aluresult_M and writedata_M, and returns readdata_M in the same cycle.
- Combines word-addressed data RAM with a small memory-mapped I/O region: LED register, free-running cycle counter, compare register and sticky timer-match flag.
- Sits between the core top and the board pins; it is the only data-side slave.

Parameters:
- DEPTH, 256, number of 32-bit RAM words (power of two, 16..4096).
- MMIO_BASE, 32'h8000_0000, base address of the MMIO window (bits [3:0] zero).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- memwrite_M  input  1  write strobe from memory stage.
- aluresult_M  input  32  byte address from memory stage.
- writedata_M  input  32  store data.
- readdata_M  output  32  load data, combinational.
- leds  output  8  LED register bits [7:0].
- timer_flag  output  1  sticky compare-match flag.

Behaviour:
- Clock and reset: one clock clk; reset is synchronous and active-high.
- Address bits [1:0] are ignored; all accesses are full words, no byte or halfword lanes.
- Decode:
  - RAM when addr < DEPTH*4; RAM index = addr[log2(DEPTH)+1:2].
  - MMIO when addr[31:4] == MMIO_BASE[31:4].
  - Anything else is unmapped.
- MMIO map, by offset addr[3:2]:
  - 0: LED register, RW; bits [31:8] read 0.
  - 1: CYCLE, RO counter; any write clears it.
  - 2: CMP, RW, 32 bits.
  - 3: STATUS; bit0 = match flag, bits [31:1] read 0; writing 1 to bit0 clears the flag.
- Reads are combinational from current state. A same-cycle write to the same address is not visible until the next cycle (read-old).
- Unmapped reads return 0; unmapped writes are ignored.
- Writes commit on the rising edge when memwrite_M=1.
- RAM contents are not affected by reset and are undefined until written.
- Reset values: LED=0, CYCLE=0, CMP=0, flag=0; therefore leds=0 and timer_flag=0 in the cycle after reset is sampled. readdata_M follows decode even during reset.
- CYCLE:
  - Increments by 1 every cycle, wrapping 32'hFFFF_FFFF -> 0.
  - A write to offset 1 loads 0 instead of incrementing.
  - Reset loads 0.
- Match:
  - When CMP != 0 and the current CYCLE == CMP, the flag sets on the next edge.
  - CMP == 0 disables matching, including CYCLE wrap through 0.
- Simultaneous flag set and STATUS write-1-clear in the same cycle: set wins (flag stays 1).
- Writing 0 to STATUS bit0 has no effect.
- Writing CMP while a match is pending: the comparison uses pre-write CMP that cycle.
- timer_flag = flag register directly, no gating.
- Reset asserted mid-sequence (e.g., during a store) discards that store to MMIO registers. A RAM write with memwrite_M=1 during reset still commits; the core keeps memwrite low during reset.

Test Plan:
- RAM store/load: write 32'hDEADBEEF to 0x10, then read 0x10 and 0x13 -> both return 32'hDEADBEEF; a same-cycle read of 0x10 during the write returns the prior value.
- LED register: write 32'h1234_56A5 to 0x8000_0000 -> leds=8'hA5 next cycle, readback 32'h0000_00A5. Then assert reset one cycle -> leds=0.
- Counter and clear:
  - After reset deassert, read 0x8000_0004 at cycle k -> returns k.
  - Write any value to 0x8000_0004 -> the following cycle reads 0, then 1.
- Timer match:
  - CMP=20 written, CYCLE cleared -> timer_flag rises on the edge after CYCLE==20.
  - Write 1 to 0x8000_000C -> flag clears.
  - Write CMP=0 -> no further set across a forced wrap.
- Set/clear collision: arrange the STATUS write-1 to coincide with the CYCLE==CMP cycle -> flag remains 1.
- Unmapped access: write 32'hFFFFFFFF to 0x4000_0000, read 0x4000_0000 and 0x8000_0010 -> both return 0, no RAM or MMIO state changed.
